spi_master_engine: RTL

Single-clock SPI master that serialises bytes from a valid/ready byte stream onto `sclk`/`cs_n`/`mosi` and returns received `miso` bytes. It sits directly upstream of the SPI slave/register block and drives its serial pins. It generates a mode-0 serial clock (CPOL=0, CPHA=0), sourced only from `clk`, at a programmable divide ratio, and frames multi-byte transfers under one chip-select.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_half_period_timer.sv | 39 +++
 rtl/spi_master_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master engine.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_DIV_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    WAIT  = 3'd4,
    TRAIL = 3'd5,
    GAP   = 3'd6
  } spi_mst_state_t;

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter timing one sclk half-period; expire is high on the
// H-th cycle after a load of period H (period must be at least 1).
module spi_half_period_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  output logic             expire
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count: reload on load, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = period - DIV_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/spi_master_engine.sv
// Mode-0 SPI master: serialises accepted bytes MSB first under one chip
// select per frame and returns the bytes shifted in on miso.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV_W  = SPI_DIV_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  spi_mst_state_t    state_q, state_d;
  logic [DIV_W-1:0]  h_q, h_d;
  logic              last_q, last_d;
  logic [DATA_W-2:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-2:0] rx_sh_q, rx_sh_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;

  logic              accept_s;
  logic              expire_s;
  logic              timer_load_s;
  logic [DIV_W-1:0]  timer_period_s;
  logic [DIV_W-1:0]  h_new_s;
  logic [CNT_W-1:0]  bit_next_s;
  logic [DATA_W-1:0] rx_byte_s;

  assign accept_s   = tx_valid & tx_ready_q;
  assign h_new_s    = (clk_div == '0) ? DIV_W'(1) : clk_div;
  assign bit_next_s = bit_cnt_q + CNT_W'(1);
  assign rx_byte_s  = {rx_sh_q, miso};

  spi_half_period_timer #(.DIV_W(DIV_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load_s),
    .period  (timer_period_s),
    .expire  (expire_s)
  );

  // Next-state and next-output logic; the timer is reloaded on every phase change.
  always_comb begin
    state_d        = state_q;
    h_d            = h_q;
    last_d         = last_q;
    tx_sh_d        = tx_sh_q;
    rx_sh_d        = rx_sh_q;
    bit_cnt_d      = bit_cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    sclk_d         = sclk_q;
    cs_n_d         = cs_n_q;
    mosi_d         = mosi_q;
    tx_ready_d     = tx_ready_q;
    busy_d         = busy_q;
    timer_load_s   = 1'b0;
    timer_period_s = h_q;
    case (state_q)
      IDLE, WAIT: begin
        // The new half-period goes straight to the timer so LEAD uses it.
        if (accept_s) begin
          state_d        = LEAD;
          h_d            = h_new_s;
          last_d         = tx_last;
          tx_sh_d        = tx_data[DATA_W-2:0];
          mosi_d         = tx_data[DATA_W-1];
          bit_cnt_d      = '0;
          cs_n_d         = 1'b0;
          tx_ready_d     = 1'b0;
          busy_d         = 1'b1;
          timer_load_s   = 1'b1;
          timer_period_s = h_new_s;
        end else begin
          state_d = state_q;
        end
      end
      LEAD, LOW: begin
        if (expire_s) begin
          state_d      = HIGH;
          sclk_d       = 1'b1;
          timer_load_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      HIGH: begin
        if (expire_s) begin
          sclk_d       = 1'b0;
          rx_sh_d      = rx_byte_s[DATA_W-2:0];
          bit_cnt_d    = bit_next_s;
          timer_load_s = 1'b1;
          if (bit_next_s == CNT_W'(DATA_W)) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_byte_s;
            if (last_q) begin
              state_d = TRAIL;
            end else begin
              state_d    = WAIT;
              tx_ready_d = 1'b1;
            end
          end else begin
            state_d = LOW;
            mosi_d  = tx_sh_q[DATA_W-2];
            tx_sh_d = {tx_sh_q[DATA_W-3:0], 1'b0};
          end
        end else begin
          state_d = state_q;
        end
      end
      TRAIL: begin
        if (expire_s) begin
          state_d      = GAP;
          cs_n_d       = 1'b1;
          timer_load_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      GAP: begin
        if (expire_s) begin
          state_d    = IDLE;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = IDLE;
        sclk_d     = 1'b0;
        cs_n_d     = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      h_q        <= DIV_W'(1);
      last_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      last_q     <= last_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;

endmodule
